// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_store_unit_if                                              |
// | Purpose  : Data-bus bundle between the load/store unit and memory.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface load_store_unit_if #(
   parameter int XLEN = 32
);
   logic            bus_req;
   logic            bus_we;
   logic [XLEN-1:0] bus_addr;
   logic [XLEN-1:0] bus_wdata;
   logic [3:0]      bus_wstrb;
   logic            bus_ack;
   logic [XLEN-1:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_store_unit                                                 |
// | Purpose  : RV32I load/store unit; one request at a time, IDLE->BUS->[WB].  |
// |            Define LSU_TIMEOUT_EN to abort bus waits after TIMEOUT_CYC.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module load_store_unit #(
   parameter int XLEN        = 32,
   parameter int REG_AW      = 5,
   parameter int TIMEOUT_CYC = 255
) (
   input  wire                 clk,
   input  wire                 rst,
   input  wire                 req_valid,
   output logic                req_ready,
   input  wire                 req_is_store,
   input  wire  [2:0]          req_funct3,
   input  wire  [XLEN-1:0]     req_addr,
   input  wire  [REG_AW-1:0]   req_rd,
   input  wire  [REG_AW-1:0]   req_rs2,
   output logic [REG_AW-1:0]   mem_read_addr,
   input  wire  [XLEN-1:0]     mem_read_data,
   load_store_unit_if.master   bus,
   input  wire                 wb_conflict,
   output logic                mem_write_en,
   output logic [REG_AW-1:0]   mem_write_addr,
   output logic [XLEN-1:0]     mem_write_data,
   output logic                busy,
   output logic                err
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_BUS  = 2'd1;
   localparam logic [1:0] c_WB   = 2'd2;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("load_store_unit: TIMEOUT_CYC must be at least 1");
   end

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [XLEN-1:0]   r_addr;
   logic [REG_AW-1:0] r_rd;
   logic [2:0]        r_funct3;
   logic              r_is_store;
   logic [3:0]        r_wstrb;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_wb_data;
   logic              r_err;

   logic              w_xfer;
   logic              w_legal_f3;
   logic              w_aligned;
   logic              w_accept;
   logic              w_reject;
   logic              w_tmo;
   logic [3:0]        w_st_wstrb;
   logic [XLEN-1:0]   w_st_wdata;
   logic [7:0]        w_rbyte;
   logic [15:0]       w_rhalf;
   logic [XLEN-1:0]   w_ld_data;

   // ---------------- request decode ----------------
   assign w_xfer = req_valid & req_ready;

   always_comb begin
      w_legal_f3 = 1'b0;
      if (req_is_store) begin
         w_legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010);
      end else begin
         w_legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                      (req_funct3 == 3'b101);
      end
   end

   always_comb begin
      case (req_funct3[1:0])
         2'b01:   w_aligned = ~req_addr[0];
         2'b10:   w_aligned = (req_addr[1:0] == 2'b00);
         default: w_aligned = 1'b1;
      endcase
   end

   assign w_accept = w_xfer & w_legal_f3 & w_aligned;
   assign w_reject = w_xfer & ~(w_legal_f3 & w_aligned);

   // Store lanes are formed at accept so the register file only needs to be read once.
   always_comb begin
      case (req_funct3[1:0])
         2'b00: begin
            w_st_wstrb = 4'b0001 << req_addr[1:0];
            w_st_wdata = {(XLEN/8){mem_read_data[7:0]}};
         end
         2'b01: begin
            w_st_wstrb = 4'b0011 << req_addr[1:0];
            w_st_wdata = {(XLEN/16){mem_read_data[15:0]}};
         end
         default: begin
            w_st_wstrb = 4'b1111;
            w_st_wdata = mem_read_data;
         end
      endcase
   end

   // ---------------- load extraction ----------------
   assign w_rbyte = bus.bus_rdata[{r_addr[1:0], 3'b000} +: 8];
   assign w_rhalf = bus.bus_rdata[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      case (r_funct3)
         3'b000:  w_ld_data = {{(XLEN-8){w_rbyte[7]}}, w_rbyte};
         3'b001:  w_ld_data = {{(XLEN-16){w_rhalf[15]}}, w_rhalf};
         3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_rbyte};
         3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_rhalf};
         default: w_ld_data = bus.bus_rdata;
      endcase
   end

   // ---------------- bus-wait timeout ----------------
`ifdef LSU_TIMEOUT_EN
   localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

   logic [c_TMO_W-1:0] r_tmo_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (w_accept) begin
         r_tmo_cnt <= '0;
      end else if (r_state == c_BUS) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_tmo = (r_state == c_BUS) && !bus.bus_ack && (r_tmo_cnt == c_TMO_LAST);
`else
   assign w_tmo = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_accept) w_state_nxt = c_BUS;
         end
         c_BUS: begin
            // A load to x0 has nothing to write back.
            if (bus.bus_ack) begin
               w_state_nxt = (r_is_store || (r_rd == '0)) ? c_IDLE : c_WB;
            end else if (w_tmo) begin
               w_state_nxt = c_IDLE;
            end
         end
         c_WB: begin
            if (!wb_conflict) w_state_nxt = c_IDLE;
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready     = (r_state == c_IDLE);
      busy          = (r_state != c_IDLE);
      bus.bus_req   = (r_state == c_BUS);
      bus.bus_we    = (r_state == c_BUS) && r_is_store;
      bus.bus_wstrb = ((r_state == c_BUS) && r_is_store) ? r_wstrb : 4'b0000;
      mem_write_en  = (r_state == c_WB);
   end

   assign bus.bus_addr   = {r_addr[XLEN-1:2], 2'b00};
   assign bus.bus_wdata  = r_wdata;
   assign mem_read_addr  = req_rs2;
   assign mem_write_addr = r_rd;
   assign mem_write_data = r_wb_data;
   assign err            = r_err;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= '0;
         r_rd       <= '0;
         r_funct3   <= '0;
         r_is_store <= 1'b0;
         r_wstrb    <= '0;
         r_wdata    <= '0;
         r_wb_data  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_reject | w_tmo;
         if (w_accept) begin
            r_addr     <= req_addr;
            r_rd       <= req_rd;
            r_funct3   <= req_funct3;
            r_is_store <= req_is_store;
            r_wstrb    <= req_is_store ? w_st_wstrb : 4'b0000;
            r_wdata    <= req_is_store ? w_st_wdata : '0;
         end
         if ((r_state == c_BUS) && bus.bus_ack && !r_is_store) begin
            r_wb_data <= w_ld_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                              |
// | Purpose  : Self-checking bench for load_store_unit with queue scoreboard.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int TMO    = 20;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [2:0]        req_funct3;
   logic [XLEN-1:0]   req_addr;
   logic [REG_AW-1:0] req_rd;
   logic [REG_AW-1:0] req_rs2;
   logic [REG_AW-1:0] mem_read_addr;
   logic [XLEN-1:0]   mem_read_data;
   logic              wb_conflict;
   logic              mem_write_en;
   logic [REG_AW-1:0] mem_write_addr;
   logic [XLEN-1:0]   mem_write_data;
   logic              busy;
   logic              err;

   logic [XLEN-1:0]   regfile [32];

   int checks;
   int errors;
   int n_wb;
   int n_err;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_t;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic [31:0] exp;
      logic [3:0]  delay;
   } ld_t;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [4:0]  rs2;
      logic [31:0] val;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } st_t;

   typedef struct packed {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
   } bad_t;

   wb_t  wb_q  [$];
   bus_t bus_q [$];

   load_store_unit_if #(.XLEN(XLEN)) bus_if ();

   load_store_unit #(
      .XLEN        (XLEN),
      .REG_AW      (REG_AW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_is_store   (req_is_store),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_rd         (req_rd),
      .req_rs2        (req_rs2),
      .mem_read_addr  (mem_read_addr),
      .mem_read_data  (mem_read_data),
      .bus            (bus_if.master),
      .wb_conflict    (wb_conflict),
      .mem_write_en   (mem_write_en),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .busy           (busy),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_data = regfile[mem_read_addr];

   // Landed write-backs and error pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_write_en && !wb_conflict) n_wb++;
      if (err) n_err++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [4:0] rs2);
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = addr;
      req_rd       = rd;
      req_rs2      = rs2;
      step();
      req_valid    = 1'b0;
      req_funct3   = 3'($urandom);
      req_addr     = $urandom;
      req_rd       = 5'($urandom);
      req_rs2      = 5'($urandom);
   endtask

   task automatic serve_bus(input int delay, input logic [31:0] rdata,
                            output bit got, output bus_t seen, output bit stable);
      got    = 1'b0;
      stable = 1'b1;
      seen   = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bus_if.bus_req) got = 1'b1;
         else step();
      end
      if (!got) return;
      seen = {bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb};
      for (int d = 0; d < delay; d++) begin
         step();
         if (!bus_if.bus_req ||
             ({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb} != seen))
            stable = 1'b0;
      end
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = rdata;
      step();
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = $urandom;
   endtask

   task automatic wait_wb(output bit got, output logic [4:0] rd, output logic [31:0] data);
      got  = 1'b0;
      rd   = '0;
      data = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (mem_write_en && !wb_conflict) begin
            got  = 1'b1;
            rd   = mem_write_addr;
            data = mem_write_data;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb, mem_write_en, err, busy} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req=%b we=%b wstrb=%b wen=%b err=%b busy=%b, expected all 0",
                  bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb, mem_write_en, err, busy);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus_if.bus_addr !== 32'h0 || mem_write_data !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wbdata=%h wdata=%h, expected 0",
                  bus_if.bus_addr, mem_write_data, bus_if.bus_wdata);
      end
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: ready=%b busy=%b, expected ready=1 busy=0", req_ready, busy);
      end
   endtask

   task automatic test_loads();
      ld_t tbl [0:8];
      bus_t exp_bus, seen;
      wb_t exp_wb;
      bit got, stable;
      logic [4:0] rd_o;
      logic [31:0] data_o;
      int wb0;
      tbl = '{
         '{3'b010, 32'h0000_0100, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd2},
         '{3'b000, 32'h0000_0103, 5'd6,  32'h8011_2233, 32'hFFFF_FF80, 4'd0},
         '{3'b100, 32'h0000_0103, 5'd7,  32'h8011_2233, 32'h0000_0080, 4'd1},
         '{3'b101, 32'h0000_0102, 5'd8,  32'h8011_2233, 32'h0000_8011, 4'd3},
         '{3'b001, 32'h0000_0102, 5'd9,  32'h8011_2233, 32'hFFFF_8011, 4'd0},
         '{3'b001, 32'h0000_0100, 5'd10, 32'h8011_2233, 32'h0000_2233, 4'd1},
         '{3'b000, 32'h0000_0101, 5'd11, 32'h8011_2233, 32'h0000_0022, 4'd0},
         '{3'b100, 32'h0000_0102, 5'd12, 32'h8011_2233, 32'h0000_0011, 4'd2},
         '{3'b101, 32'h0000_0100, 5'd13, 32'h8011_F2A3, 32'h0000_F2A3, 4'd0}
      };
      for (int i = 0; i < 9; i++) begin
         bus_q.push_back(bus_t'{we: 1'b0, addr: tbl[i].addr & 32'hFFFF_FFFC, wdata: 32'h0, wstrb: 4'b0000});
         wb_q.push_back(wb_t'{rd: tbl[i].rd, data: tbl[i].exp});
         wb0 = n_wb;
         send_req(1'b0, tbl[i].f3, tbl[i].addr, tbl[i].rd, 5'd0);
         serve_bus(int'(tbl[i].delay), tbl[i].rdata, got, seen, stable);
         exp_bus = bus_q.pop_front();
         checks++;
         if (!got || !stable || seen.we !== exp_bus.we || seen.addr !== exp_bus.addr ||
             seen.wstrb !== exp_bus.wstrb) begin
            errors++;
            $display("FAIL load_bus[%0d]: got=%0b stable=%0b we=%b addr=%h wstrb=%b, expected got=1 stable=1 we=0 addr=%h wstrb=0000",
                     i, got, stable, seen.we, seen.addr, seen.wstrb, exp_bus.addr);
         end
         wait_wb(got, rd_o, data_o);
         exp_wb = wb_q.pop_front();
         checks++;
         if (!got || rd_o !== exp_wb.rd || data_o !== exp_wb.data) begin
            errors++;
            $display("FAIL load_wb[%0d]: got=%0b rd=%0d data=%h, expected rd=%0d data=%h",
                     i, got, rd_o, data_o, exp_wb.rd, exp_wb.data);
         end
         checks++;
         if ((n_wb - wb0) != 1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done[%0d]: writes=%0d ready=%b, expected writes=1 ready=1",
                     i, n_wb - wb0, req_ready);
         end
      end
   endtask

   task automatic test_stores();
      st_t tbl [0:3];
      bus_t exp_bus, seen;
      bit got, stable;
      int wb0;
      tbl = '{
         '{3'b001, 32'h0000_0202, 5'd7,  32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD},
         '{3'b000, 32'h0000_0201, 5'd12, 32'h1234_56CD, 4'b0010, 32'hCDCD_CDCD},
         '{3'b010, 32'h0000_0204, 5'd8,  32'h1234_5678, 4'b1111, 32'h1234_5678},
         '{3'b000, 32'h0000_0203, 5'd13, 32'hFFFF_FFA5, 4'b1000, 32'hA5A5_A5A5}
      };
      for (int i = 0; i < 4; i++) begin
         regfile[tbl[i].rs2] = tbl[i].val;
         bus_q.push_back(bus_t'{we: 1'b1, addr: tbl[i].addr & 32'hFFFF_FFFC,
                                wdata: tbl[i].wdata, wstrb: tbl[i].wstrb});
         wb0 = n_wb;
         send_req(1'b1, tbl[i].f3, tbl[i].addr, 5'd30, tbl[i].rs2);
         regfile[tbl[i].rs2] = ~tbl[i].val;
         serve_bus(2, 32'h0, got, seen, stable);
         exp_bus = bus_q.pop_front();
         checks++;
         if (!got || !stable || seen !== exp_bus) begin
            errors++;
            $display("FAIL store_bus[%0d]: got=%0b stable=%0b we=%b addr=%h wdata=%h wstrb=%b, expected we=1 addr=%h wdata=%h wstrb=%b",
                     i, got, stable, seen.we, seen.addr, seen.wdata, seen.wstrb,
                     exp_bus.addr, exp_bus.wdata, exp_bus.wstrb);
         end
         checks++;
         if (req_ready !== 1'b1 || bus_if.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL store_ready[%0d]: ready=%b req=%b, expected ready=1 req=0",
                     i, req_ready, bus_if.bus_req);
         end
         step();
         step();
         checks++;
         if ((n_wb - wb0) != 0) begin
            errors++;
            $display("FAIL store_nowb[%0d]: writes=%0d, expected 0", i, n_wb - wb0);
         end
      end
   endtask

   task automatic test_illegal();
      bad_t tbl [0:5];
      int e0;
      bit bad;
      tbl = '{
         '{1'b0, 3'b010, 32'h0000_0101},
         '{1'b0, 3'b011, 32'h0000_0100},
         '{1'b0, 3'b001, 32'h0000_0101},
         '{1'b0, 3'b110, 32'h0000_0100},
         '{1'b1, 3'b100, 32'h0000_0100},
         '{1'b1, 3'b010, 32'h0000_0102}
      };
      for (int i = 0; i < 6; i++) begin
         e0 = n_err;
         send_req(tbl[i].st, tbl[i].f3, tbl[i].addr, 5'd4, 5'd1);
         checks++;
         if (err !== 1'b1 || bus_if.bus_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err[%0d]: err=%b req=%b ready=%b, expected err=1 req=0 ready=1",
                     i, err, bus_if.bus_req, req_ready);
         end
         step();
         bad = 1'b0;
         for (int c = 0; c < 2; c++) begin
            if (bus_if.bus_req || busy || err) bad = 1'b1;
            step();
         end
         checks++;
         if (bad || (n_err - e0) != 1) begin
            errors++;
            $display("FAIL illegal_after[%0d]: activity=%0b pulses=%0d, expected activity=0 pulses=1",
                     i, bad, n_err - e0);
         end
      end
   endtask

   task automatic test_conflict();
      bus_t seen;
      wb_t exp_wb;
      bit got, stable;
      int wb0, en_cnt;
      logic [4:0] rd_o;
      logic [31:0] data_o;
      wb0    = n_wb;
      en_cnt = 0;
      rd_o   = '0;
      data_o = '0;
      wb_q.push_back(wb_t'{rd: 5'd3, data: 32'h0BAD_F00D});
      wb_conflict = 1'b1;
      send_req(1'b0, 3'b010, 32'h0000_0300, 5'd3, 5'd0);
      serve_bus(1, 32'h0BAD_F00D, got, seen, stable);
      for (int c = 0; c < 8; c++) begin
         if (mem_write_en) en_cnt++;
         if (c == 2) begin
            wb_conflict = 1'b0;
            rd_o        = mem_write_addr;
            data_o      = mem_write_data;
         end
         step();
      end
      exp_wb = wb_q.pop_front();
      checks++;
      if (!got || en_cnt != 3 || (n_wb - wb0) != 1) begin
         errors++;
         $display("FAIL conflict_hold: got=%0b en_cycles=%0d writes=%0d, expected en_cycles=3 writes=1",
                  got, en_cnt, n_wb - wb0);
      end
      checks++;
      if (rd_o !== exp_wb.rd || data_o !== exp_wb.data) begin
         errors++;
         $display("FAIL conflict_data: rd=%0d data=%h, expected rd=%0d data=%h",
                  rd_o, data_o, exp_wb.rd, exp_wb.data);
      end
   endtask

   task automatic test_x0();
      bus_t seen;
      bit got, stable;
      int wb0;
      wb0 = n_wb;
      send_req(1'b0, 3'b010, 32'h0000_0104, 5'd0, 5'd0);
      serve_bus(0, 32'h1111_2222, got, seen, stable);
      checks++;
      if (!got || mem_write_en !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_skip: got=%0b wen=%b ready=%b, expected got=1 wen=0 ready=1",
                  got, mem_write_en, req_ready);
      end
      step();
      step();
      checks++;
      if ((n_wb - wb0) != 0) begin
         errors++;
         $display("FAIL x0_nowb: writes=%0d, expected 0", n_wb - wb0);
      end
   endtask

   task automatic test_ack_ignored();
      int wb0, e0;
      wb0 = n_wb;
      e0  = n_err;
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'hCAFE_CAFE;
      step();
      bus_if.bus_ack   = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || (n_wb - wb0) != 0 || (n_err - e0) != 0) begin
         errors++;
         $display("FAIL idle_ack: busy=%b ready=%b writes=%0d errs=%0d, expected busy=0 ready=1 writes=0 errs=0",
                  busy, req_ready, n_wb - wb0, n_err - e0);
      end
   endtask

   task automatic test_reset_mid_bus();
      int wb0;
      wb0 = n_wb;
      send_req(1'b0, 3'b010, 32'h0000_0400, 5'd9, 5'd0);
      step();
      checks++;
      if (bus_if.bus_req !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: req=%b busy=%b, expected req=1 busy=1", bus_if.bus_req, busy);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus_if.bus_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: req=%b busy=%b, expected req=0 busy=0", bus_if.bus_req, busy);
      end
      step();
      rst = 1'b0;
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h5555_AAAA;
      step();
      bus_if.bus_ack   = 1'b0;
      step();
      step();
      checks++;
      if (busy !== 1'b0 || mem_write_en !== 1'b0 || (n_wb - wb0) != 0) begin
         errors++;
         $display("FAIL rst_abort: busy=%b wen=%b writes=%0d, expected busy=0 wen=0 writes=0",
                  busy, mem_write_en, n_wb - wb0);
      end
   endtask

`ifdef LSU_TIMEOUT_EN
   task automatic test_timeout();
      int req_cycles, wb0;
      bit seen_err;
      req_cycles = 0;
      seen_err   = 1'b0;
      wb0        = n_wb;
      send_req(1'b0, 3'b010, 32'h0000_0500, 5'd4, 5'd0);
      for (int i = 0; i < TMO + 10 && !seen_err; i++) begin
         if (bus_if.bus_req) req_cycles++;
         if (err) seen_err = 1'b1;
         else step();
      end
      checks++;
      if (!seen_err || req_cycles != TMO || bus_if.bus_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout: err_seen=%0b req_cycles=%0d req=%b, expected err_seen=1 req_cycles=%0d req=0",
                  seen_err, req_cycles, bus_if.bus_req, TMO);
      end
      step();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || (n_wb - wb0) != 0) begin
         errors++;
         $display("FAIL timeout_after: err=%b busy=%b writes=%0d, expected 0 0 0",
                  err, busy, n_wb - wb0);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      n_wb   = 0;
      n_err  = 0;
      for (int i = 0; i < 32; i++) regfile[i] = '0;
      rst              = 1'b1;
      req_valid        = 1'b0;
      req_is_store     = 1'b0;
      req_funct3       = 3'b000;
      req_addr         = '0;
      req_rd           = '0;
      req_rs2          = '0;
      wb_conflict      = 1'b0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;

      test_reset();
      test_loads();
      test_stores();
      test_illegal();
      test_conflict();
      test_x0();
      test_ack_ignored();
      test_reset_mid_bus();
`ifdef LSU_TIMEOUT_EN
      test_timeout();
`endif

      checks++;
      if (wb_q.size() != 0 || bus_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: wb_left=%0d bus_left=%0d, expected 0 0",
                  wb_q.size(), bus_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
